// File: rtl/alu_param_core.sv
// Parametrised ALU core: collects operands (possibly on different cycles), runs one
// command (multi-cycle for MUL), and returns a registered result with flags.
module alu_param_core #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16,
    parameter int MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               mode,
    input  logic [3:0]         cmd,
    input  logic [1:0]         inp_valid,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               cin,
    output logic [2*WIDTH-1:0] res,
    output logic               res_valid,
    output logic               cout,
    output logic               oflow,
    output logic               g,
    output logic               l,
    output logic               e,
    output logic               err,
    output logic               busy,
    output logic [1:0]         state_dbg
);
    localparam int LG = $clog2(WIDTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_OP = 2'd1, EXEC = 2'd2} state_t;
    state_t state_q, state_d;

    // Handshake: inp_valid bits qualify opa/opb on ce=1 edges in IDLE/WAIT_OP only; there is
    // no ready. res_valid is a one-cycle qualifier with no back-pressure.
    logic               mode_q, cin_q, have_a_q, err_q, rv_q;
    logic [3:0]         cmd_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic [TW-1:0]      timer_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] res_q;
    logic               cout_q, oflow_q, g_q, l_q, e_q, err_r;

    logic capture, cap_err, take_a, take_b, timer_clr, timer_inc, cnt_clr, cnt_inc;
    logic finish, timeout, is_mul;
    logic [2:0] req;

    // {legal, needs_a, needs_b}
    function automatic logic [2:0] op_req(input logic m, input logic [3:0] c);
        logic [2:0] r;
        r = 3'b000;
        if (m) begin
            case (c)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11: r = 3'b111;
                4'd4, 4'd5: r = 3'b110;
                4'd6, 4'd7: r = 3'b101;
                default:    r = 3'b000;
            endcase
        end else begin
            case (c)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13: r = 3'b111;
                4'd6, 4'd8, 4'd9:  r = 3'b110;
                4'd7, 4'd10, 4'd11: r = 3'b101;
                default:            r = 3'b000;
            endcase
        end
        return r;
    endfunction

    assign req    = op_req(mode, cmd);
    assign is_mul = mode_q && (cmd_q == 4'd9) && !err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        cap_err   = 1'b0;
        take_a    = 1'b0;
        take_b    = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        finish    = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ce && inp_valid != 2'b00) begin
                    capture = 1'b1;
                    take_a  = inp_valid[0];
                    take_b  = inp_valid[1];
                    cnt_clr = 1'b1;
                    state_d = EXEC;
                    if (!req[2]) begin
                        cap_err = 1'b1;
                    end else if (req[1] && req[0]) begin
                        if (inp_valid != 2'b11) begin
                            state_d   = WAIT_OP;
                            timer_clr = 1'b1;
                        end
                    end else begin
                        cap_err = !((req[1] && inp_valid[0]) || (req[0] && inp_valid[1]));
                    end
                end
            end
            WAIT_OP: begin
                if (ce) begin
                    timer_inc = 1'b1;
                    take_a    = inp_valid[0];
                    take_b    = inp_valid[1];
                    if (have_a_q ? inp_valid[1] : inp_valid[0]) begin
                        state_d = EXEC;
                        cnt_clr = 1'b1;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        finish  = 1'b1;
                        timeout = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            EXEC: begin
                if (ce) begin
                    if (!is_mul || cnt_q == CW'(MUL_LAT - 1)) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath operates on the latched operands; MUL is a multicycle path of MUL_LAT edges.
    logic [WIDTH:0]     a_x, b_x, cin_x, one_x;
    logic [WIDTH:0]     add_w, addc_w, sub_w, subc_w, inca_w, deca_w, incb_w, decb_w;
    logic [WIDTH-1:0]   sadd_w, ssub_w, rol_w, ror_w, lres;
    logic [2*WIDTH-1:0] prod_w, rotl_w, rotr_w, r_res;
    logic               r_cout, r_oflow, r_g, r_l, r_e, r_err, rot_bad;

    assign a_x    = {1'b0, opa_q};
    assign b_x    = {1'b0, opb_q};
    assign cin_x  = {{WIDTH{1'b0}}, cin_q};
    assign one_x  = {{WIDTH{1'b0}}, 1'b1};
    assign add_w  = a_x + b_x;
    assign addc_w = a_x + b_x + cin_x;
    assign sub_w  = a_x - b_x;
    assign subc_w = a_x - b_x - cin_x;
    assign inca_w = a_x + one_x;
    assign deca_w = a_x - one_x;
    assign incb_w = b_x + one_x;
    assign decb_w = b_x - one_x;
    assign sadd_w = opa_q + opb_q;
    assign ssub_w = opa_q - opb_q;
    assign prod_w = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};
    assign rotl_w = {opa_q, opa_q} << opb_q[LG-1:0];
    assign rotr_w = {opa_q, opa_q} >> opb_q[LG-1:0];
    assign rol_w  = rotl_w[2*WIDTH-1:WIDTH];
    assign ror_w  = rotr_w[WIDTH-1:0];
    assign rot_bad = |opb_q[WIDTH-1:LG];

    always_comb begin
        r_res   = '0;
        r_cout  = 1'b0;
        r_oflow = 1'b0;
        r_g     = 1'b0;
        r_l     = 1'b0;
        r_e     = 1'b0;
        r_err   = 1'b0;
        lres    = '0;
        if (err_q || timeout) begin
            r_err = 1'b1;
        end else if (mode_q) begin
            case (cmd_q)
                4'd0:  begin r_res = {{(WIDTH-1){1'b0}}, add_w};  r_cout = add_w[WIDTH];  end
                4'd1:  begin r_res = {{WIDTH{1'b0}}, sub_w[WIDTH-1:0]};  r_cout = sub_w[WIDTH];  end
                4'd2:  begin r_res = {{(WIDTH-1){1'b0}}, addc_w}; r_cout = addc_w[WIDTH]; end
                4'd3:  begin r_res = {{WIDTH{1'b0}}, subc_w[WIDTH-1:0]}; r_cout = subc_w[WIDTH]; end
                4'd4:  begin r_res = {{(WIDTH-1){1'b0}}, inca_w}; r_cout = inca_w[WIDTH]; end
                4'd5:  begin r_res = {{WIDTH{1'b0}}, deca_w[WIDTH-1:0]}; r_cout = deca_w[WIDTH]; end
                4'd6:  begin r_res = {{(WIDTH-1){1'b0}}, incb_w}; r_cout = incb_w[WIDTH]; end
                4'd7:  begin r_res = {{WIDTH{1'b0}}, decb_w[WIDTH-1:0]}; r_cout = decb_w[WIDTH]; end
                4'd8:  begin r_g = opa_q > opb_q; r_l = opa_q < opb_q; r_e = opa_q == opb_q; end
                4'd9:  r_res = prod_w;
                4'd10: begin
                    r_res   = {{WIDTH{1'b0}}, sadd_w};
                    r_oflow = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (sadd_w[WIDTH-1] != opa_q[WIDTH-1]);
                end
                4'd11: begin
                    r_res   = {{WIDTH{1'b0}}, ssub_w};
                    r_oflow = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) && (ssub_w[WIDTH-1] != opa_q[WIDTH-1]);
                end
                default: r_err = 1'b1;
            endcase
        end else begin
            case (cmd_q)
                4'd0:  lres = opa_q & opb_q;
                4'd1:  lres = ~(opa_q & opb_q);
                4'd2:  lres = opa_q | opb_q;
                4'd3:  lres = ~(opa_q | opb_q);
                4'd4:  lres = opa_q ^ opb_q;
                4'd5:  lres = ~(opa_q ^ opb_q);
                4'd6:  lres = ~opa_q;
                4'd7:  lres = ~opb_q;
                4'd8:  lres = opa_q >> 1;
                4'd9:  lres = opa_q << 1;
                4'd10: lres = opb_q >> 1;
                4'd11: lres = opb_q << 1;
                4'd12: if (rot_bad) r_err = 1'b1; else lres = rol_w;
                4'd13: if (rot_bad) r_err = 1'b1; else lres = ror_w;
                default: r_err = 1'b1;
            endcase
            r_res = {{WIDTH{1'b0}}, lres};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0; cmd_q <= '0; cin_q <= 1'b0; have_a_q <= 1'b0; err_q <= 1'b0;
            opa_q <= '0; opb_q <= '0; timer_q <= '0; cnt_q <= '0; rv_q <= 1'b0;
            res_q <= '0; cout_q <= 1'b0; oflow_q <= 1'b0;
            g_q <= 1'b0; l_q <= 1'b0; e_q <= 1'b0; err_r <= 1'b0;
        end else begin
            if (capture) begin
                mode_q   <= mode;
                cmd_q    <= cmd;
                cin_q    <= cin;
                have_a_q <= inp_valid[0];
                err_q    <= cap_err;
            end
            if (take_a) opa_q <= opa;
            if (take_b) opb_q <= opb;
            if (timer_clr)      timer_q <= '0;
            else if (timer_inc) timer_q <= timer_q + TW'(1);
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + CW'(1);
            rv_q <= finish;
            if (finish) begin
                res_q <= r_res; cout_q <= r_cout; oflow_q <= r_oflow;
                g_q <= r_g; l_q <= r_l; e_q <= r_e; err_r <= r_err;
            end
        end
    end

    assign res       = res_q;
    assign res_valid = rv_q & ce;
    assign cout      = cout_q;
    assign oflow     = oflow_q;
    assign g         = g_q;
    assign l         = l_q;
    assign e         = e_q;
    assign err       = err_r;
    assign busy      = (state_q == EXEC);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_alu_param_core.sv
// Directed self-checking bench for alu_param_core at WIDTH=8, TIMEOUT=16, MUL_LAT=3.
module tb_alu_param_core;
    logic        clk = 1'b0;
    logic        rst_n, ce, mode, cin;
    logic [3:0]  cmd;
    logic [1:0]  inp_valid;
    logic [7:0]  opa, opb;
    logic [15:0] res;
    logic        res_valid, cout, oflow, g, l, e, err, busy;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    typedef struct packed {
        logic       m;
        logic [3:0] c;
        logic       ci;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] r;
        logic [5:0] f;  // {cout, oflow, g, l, e, err}
    } vec_t;
    vec_t vecs[$];

    alu_param_core #(.WIDTH(8), .TIMEOUT(16), .MUL_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .mode(mode), .cmd(cmd),
        .inp_valid(inp_valid), .opa(opa), .opb(opb), .cin(cin),
        .res(res), .res_valid(res_valid), .cout(cout), .oflow(oflow),
        .g(g), .l(l), .e(e), .err(err), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] iv, input logic ci);
        mode = m; cmd = c; opa = a; opb = b; inp_valid = iv; cin = ci;
    endtask

    task automatic add_3_4(input string tag);
        apply(1'b1, 4'd0, 8'h03, 8'h04, 2'b11, 1'b0);
        tick();
        inp_valid = 2'b00;
        tick();
        check({tag, "_rv"}, 32'(res_valid), 32'd1);
        check({tag, "_res"}, 32'(res), 32'h0007);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int seen;
        vec_t v;
        logic [15:0] exp_r;
        rst_n = 1'b0; ce = 1'b1;
        apply(1'b0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        check("rst_res", 32'(res), 32'h0);
        check("rst_flags", 32'({res_valid, busy, cout, oflow, g, l, e, err}), 32'h0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD FF+01 with pulse width and hold checks
        apply(1'b1, 4'd0, 8'hFF, 8'h01, 2'b11, 1'b0);
        tick();
        inp_valid = 2'b00;
        check("add_busy", 32'(busy), 32'd1);
        check("add_rv_early", 32'(res_valid), 32'd0);
        tick();
        check("add_rv", 32'(res_valid), 32'd1);
        check("add_res", 32'(res), 32'h0100);
        check("add_cout", 32'(cout), 32'd1);
        tick();
        check("add_rv_off", 32'(res_valid), 32'd0);
        check("add_hold", 32'(res), 32'h0100);

        // SUB with operands split, OPB five edges later
        apply(1'b1, 4'd1, 8'h10, 8'h00, 2'b01, 1'b0);
        tick();
        inp_valid = 2'b00;
        check("sub_wait", 32'(state_dbg), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        opb = 8'h20; inp_valid = 2'b10;
        tick();
        inp_valid = 2'b00;
        check("sub_rv_early", 32'(res_valid), 32'd0);
        tick();
        check("sub_rv", 32'(res_valid), 32'd1);
        check("sub_res", 32'(res), 32'h00F0);
        check("sub_cout", 32'(cout), 32'd1);
        check("sub_err", 32'(err), 32'd0);

        // timeout after 16 edges
        apply(1'b1, 4'd0, 8'h03, 8'h00, 2'b01, 1'b0);
        tick();
        inp_valid = 2'b00;
        seen = 0;
        for (int i = 0; i < 15; i++) begin tick(); if (res_valid) seen++; end
        check("to_no_early", 32'(seen), 32'd0);
        tick();
        check("to_rv", 32'(res_valid), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_res", 32'(res), 32'h0);
        tick();
        add_3_4("after_to");

        // timeout stretched by 4 CE-low edges
        tick();
        apply(1'b1, 4'd0, 8'h03, 8'h00, 2'b01, 1'b0);
        tick();
        inp_valid = 2'b00;
        ce = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("ce_hold_state", 32'(state_dbg), 32'd1);
        ce = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin tick(); if (res_valid) seen++; end
        check("ce_to_no_early", 32'(seen), 32'd0);
        tick();
        check("ce_to_rv", 32'(res_valid), 32'd1);
        check("ce_to_err", 32'(err), 32'd1);
        tick();

        // MUL FF*FF, new operands during BUSY ignored
        apply(1'b1, 4'd9, 8'hFF, 8'hFF, 2'b11, 1'b0);
        tick();
        apply(1'b1, 4'd0, 8'h01, 8'h01, 2'b11, 1'b0);
        check("mul_busy1", 32'({busy, res_valid}), 32'b10);
        tick();
        check("mul_busy2", 32'({busy, res_valid}), 32'b10);
        tick();
        inp_valid = 2'b00;
        check("mul_busy3", 32'({busy, res_valid}), 32'b10);
        tick();
        check("mul_rv", 32'({busy, res_valid}), 32'b01);
        check("mul_res", 32'(res), 32'hFE01);
        tick();
        check("mul_idle", 32'({state_dbg, res_valid}), 32'b000);

        // table of single-latency vectors, scoreboarded through exp_q
        vecs.push_back('{1'b1, 4'd2,  1'b1, 8'h0F, 8'h01, 16'h0011, 6'b000000});
        vecs.push_back('{1'b1, 4'd3,  1'b1, 8'h05, 8'h05, 16'h00FF, 6'b100000});
        vecs.push_back('{1'b1, 4'd10, 1'b0, 8'h7F, 8'h01, 16'h0080, 6'b010000});
        vecs.push_back('{1'b1, 4'd11, 1'b0, 8'h80, 8'h01, 16'h007F, 6'b010000});
        vecs.push_back('{1'b1, 4'd5,  1'b0, 8'h00, 8'h55, 16'h00FF, 6'b100000});
        vecs.push_back('{1'b1, 4'd6,  1'b0, 8'h00, 8'hFF, 16'h0100, 6'b100000});
        vecs.push_back('{1'b1, 4'd8,  1'b0, 8'h05, 8'h09, 16'h0000, 6'b000100});
        vecs.push_back('{1'b1, 4'd8,  1'b0, 8'h09, 8'h09, 16'h0000, 6'b000010});
        vecs.push_back('{1'b1, 4'd8,  1'b0, 8'hA0, 8'h09, 16'h0000, 6'b001000});
        vecs.push_back('{1'b0, 4'd4,  1'b0, 8'hA5, 8'h0F, 16'h00AA, 6'b000000});
        vecs.push_back('{1'b0, 4'd1,  1'b0, 8'hF0, 8'hFF, 16'h000F, 6'b000000});
        vecs.push_back('{1'b0, 4'd11, 1'b0, 8'h00, 8'h81, 16'h0002, 6'b000000});
        vecs.push_back('{1'b0, 4'd12, 1'b0, 8'h81, 8'h01, 16'h0003, 6'b000000});
        vecs.push_back('{1'b0, 4'd13, 1'b0, 8'h01, 8'h01, 16'h0080, 6'b000000});
        vecs.push_back('{1'b0, 4'd12, 1'b0, 8'h81, 8'h10, 16'h0000, 6'b000001});
        vecs.push_back('{1'b1, 4'd13, 1'b0, 8'h12, 8'h34, 16'h0000, 6'b000001});
        foreach (vecs[i]) begin
            v = vecs[i];
            exp_q.push_back(v.r);
            apply(v.m, v.c, v.a, v.b, 2'b11, v.ci);
            tick();
            inp_valid = 2'b00;
            tick();
            exp_r = exp_q.pop_front();
            check($sformatf("vec%0d_rv", i), 32'(res_valid), 32'd1);
            check($sformatf("vec%0d_res", i), 32'(res), 32'(exp_r));
            check($sformatf("vec%0d_flags", i), 32'({cout, oflow, g, l, e, err}), 32'(v.f));
        end

        // single-operand command given only the wrong operand
        apply(1'b0, 4'd9, 8'h00, 8'h11, 2'b10, 1'b0);
        tick();
        inp_valid = 2'b00;
        tick();
        check("wrong_op", 32'({res_valid, err, res}), {14'd0, 2'b11, 16'h0});

        // reset one edge into MUL EXEC
        apply(1'b1, 4'd9, 8'hFF, 8'hFF, 2'b11, 1'b0);
        tick();
        inp_valid = 2'b00;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mrst_res", 32'(res), 32'h0);
        check("mrst_flags", 32'({res_valid, busy, cout, oflow, g, l, e, err}), 32'h0);
        tick();
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (res_valid) seen++; end
        check("mrst_no_rv", 32'(seen), 32'd0);
        add_3_4("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
